ip_send: RTL
============

# ip_send

IPv4 encapsulation stage directly downstream of the UDP sender. Accepts a UDP segment as a 32-bit beat stream with destination IP and UDP length, and prepends a 20-byte IPv4 header (five 32-bit words). Queues the payload in an internal FIFO while the header is emitted. Presents the IP datagram, its total length and the destination IP to the link/ARP stage.

## Interface
- SRC_IP, 32'hC0A8010A, source address placed in header word 3
- TTL, 8'd64, time-to-live field
- DEPTH, 16, data FIFO depth in beats (power of two, ≥ 8)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- data_in  in  32  UDP beat, big-endian byte order, byte 0 in [31:24]
- data_valid_in  in  1  beat valid; no backpressure exists upstream
- data_keep_in  in  4  byte enables; [3] = byte in [31:24]
- data_last_in  in  1  final beat of segment
- ip_addr_in  in  32  destination IP; sampled on first beat only
- length_in  in  16  UDP length incl. 8-byte UDP header; sampled on first beat only
- data_out  out  32  IP datagram beat
- data_valid_out  out  1  output beat valid
- data_keep_out  out  4  output byte enables
- data_last_out  out  1  final datagram beat
- length_out  out  16  IP total length, held stable for the whole datagram
- ip_addr_out  out  32  destination IP, held stable for the whole datagram
- overflow_err  out  1  sticky; set on data or metadata overflow, cleared only by reset

## Operation
- First beat: the first valid beat after reset, or the first valid beat after a beat with last=1.
- On each first beat, {ip_addr_in, length_in} is pushed into a 2-entry metadata queue.
- Every valid beat is written, with its keep and last, into the data FIFO.
- FSM states:
  - IDLE: when the metadata queue is non-empty, pop one entry, latch total_len = length_in + 20 (16-bit, wraps), go to HDR.
  - HDR: emit words 0–4, one per cycle, with keep=4'hF and last=0, then go to DATA.
  - DATA: pop one FIFO beat per cycle while the FIFO is non-empty and forward it unchanged; valid=0 on cycles with no beat; after the beat with last=1 is forwarded, go to IDLE.
- Header words:
  - w0 = {8'h45, 8'h00, total_len}
  - w1 = {ident, 16'h4000} (DF set)
  - w2 = {TTL, 8'h11, csum}
  - w3 = SRC_IP
  - w4 = destination IP
- ident: 16-bit counter, reset 0, increments after each w1 is emitted, wraps FFFF→0000.
- Overflow:
  - A write to a full data FIFO drops that beat.
  - A first beat arriving with the metadata queue full drops the whole packet.
  - Both cases set overflow_err.
  - The following packet is unaffected.

## Timing
- Reset values of all outputs are 0; FIFO, metadata queue and ident are cleared; FSM returns to IDLE.
- An assertion of reset mid-datagram aborts it with no further output.
- Latency: first input beat at cycle N → w0 on data_out at N+2 (N+1 metadata registered, N+2 first header beat).
- A contiguous segment of k beats yields k+5 contiguous output beats.
- A new packet's first beat may coincide with the previous packet's last beat being popped. Its datagram then starts in IDLE on the next cycle, giving one idle output cycle between datagrams.
- length_out and ip_addr_out update in the IDLE→HDR transition cycle.

## Configuration
- IP_CHECKSUM_EN defined:
  - csum is the ones'-complement of the end-around-carry 16-bit sum of w0, w1, w2 (csum field = 0), w3 and w4.
  - The sum is computed over two registered cycles during HDR and is ready before w2.
- IP_CHECKSUM_EN undefined: csum = 16'h0000 and no adder logic is instantiated.

## Structure
- Package ip_pkg holds:
  - IP_VER_IHL = 8'h45
  - IP_PROTO_UDP = 8'h11
  - IP_FLAGS_DF = 16'h4000
  - IP_HDR_BYTES = 20
  - IP_HDR_WORDS = 5
  - FSM state enum {IDLE, HDR, DATA}
- Sub-module ip_stream_fifo: synchronous FIFO of {last, keep, data}, 37 bits wide, DEPTH deep, with full/empty flags and async reset.

## Test plan
- Checksum: SRC_IP C0A8010A, dst C0A80114, length_in 0x0010, 4 beats → w0=45000024, w1=00004000, w2=4011B75A (IP_CHECKSUM_EN) or 40110000 (undefined), w3=C0A8010A, w4=C0A80114, then 4 payload beats; length_out=0x0024.
- Partial last beat: last beat keep=4'b1100 → forwarded with keep 1100 and last=1; all header beats keep=F.
- Back-to-back packets: two 3-beat packets, second first beat one cycle after first last → 8 beats, 1 idle cycle, 8 beats; ident 0 then 1; second datagram's ip_addr_out/length_out correct.
- Overflow: DEPTH=8, three 10-beat packets with no gaps → overflow_err=1; the datagram following the drop is intact.
- Reset: assert reset during w3 → all outputs 0 the next cycle; a new packet after release starts with ident 0.

Source files
------------

// File: rtl/ip_pkg.sv
// ip_pkg: shared constants, FSM state type and checksum helper for the IPv4
// encapsulation stage (ip_send) and its payload FIFO (ip_stream_fifo).
package ip_pkg;

  localparam logic [7:0]  IP_VER_IHL   = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP = 8'h11;
  localparam logic [15:0] IP_FLAGS_DF  = 16'h4000;
  localparam int unsigned IP_HDR_BYTES = 20;
  localparam int unsigned IP_HDR_WORDS = 5;

  // FIFO entry is {last, keep[3:0], data[31:0]}
  localparam int unsigned BEAT_W = 37;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] len;
  } meta_t;

  // End-around-carry reduction of a sum of up to sixteen 16-bit terms.
  // After the first fold a carry leaves the low half <= 16'h000E, so the
  // second fold can never carry again.
  function automatic logic [15:0] fold_sum(input logic [19:0] s);
    logic [16:0] f1;
    f1 = {1'b0, s[15:0]} + 17'(s[19:16]);
    return f1[15:0] + 16'(f1[16]);
  endfunction

endpackage

// File: rtl/ip_stream_fifo.sv
// ip_stream_fifo: synchronous first-word-fall-through FIFO for payload beats.
// Ports:
//   clk, reset          clock, asynchronous active-high reset (clears pointers)
//   wr_en, wr_data      write request; ignored while full
//   mark_last           while full, set the last flag of the newest entry
//   rd_en               pop the head entry; ignored while empty
//   rd_data             head entry (valid whenever empty is low)
//   full, empty         occupancy flags
module ip_stream_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             mark_last,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    tail;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tail    = wr_ptr[AW-1:0] - AW'(1);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // When full the tail is never the head (DEPTH >= 8), so it cannot be
  // popped in the same cycle it is re-flagged.
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    else if (mark_last && full) mem[tail][WIDTH-1] <= 1'b1;
  end

endmodule

// File: rtl/ip_send.sv
// ip_send: prepends a 20-byte IPv4 header to UDP segments.
// Optional feature macro: IP_CHECKSUM_EN (header checksum; otherwise 0).
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   data_in/_valid_in/_keep_in/_last_in  UDP beat stream (no backpressure)
//   ip_addr_in, length_in            destination IP / UDP length, first beat
//   data_out/_valid_out/_keep_out/_last_out  IP datagram beat stream
//   length_out, ip_addr_out          total length / destination of datagram
//   overflow_err                     sticky data/metadata overflow flag
module ip_send
  import ip_pkg::*;
#(
  parameter logic [31:0] SRC_IP = 32'hC0A8010A,
  parameter logic [7:0]  TTL    = 8'd64,
  parameter int unsigned DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        data_valid_in,
  input  logic [3:0]  data_keep_in,
  input  logic        data_last_in,
  input  logic [31:0] ip_addr_in,
  input  logic [15:0] length_in,
  output logic [31:0] data_out,
  output logic        data_valid_out,
  output logic [3:0]  data_keep_out,
  output logic        data_last_out,
  output logic [15:0] length_out,
  output logic [31:0] ip_addr_out,
  output logic        overflow_err
);

  state_t state, state_next;
  logic [2:0]  hdr_idx;
  logic [15:0] ident;
  logic [15:0] csum;
  logic [31:0] hdr_word;

  // input side
  logic in_pkt, drop_pkt, first, drop_now, ovf_event;
  logic meta_push, meta_pop, meta_full;
  meta_t meta_q [2];
  logic  meta_wr, meta_rd;
  logic [1:0] meta_cnt;

  logic fifo_wr, fifo_rd, fifo_mark, fifo_full, fifo_empty;
  logic [BEAT_W-1:0] fifo_rdata;

  assign first     = data_valid_in && !in_pkt;
  assign meta_full = (meta_cnt == 2'd2);
  assign meta_pop  = (state == IDLE) && (meta_cnt != 2'd0);
  // A packet whose first beat finds either queue full is dropped whole, so
  // data never enters the FIFO without a matching metadata entry.
  assign drop_now  = first ? (meta_full || fifo_full) : drop_pkt;
  assign meta_push = first && !drop_now;
  assign fifo_wr   = data_valid_in && !drop_now && !fifo_full;
  // A last beat lost to a full FIFO still terminates its packet by flagging
  // the newest stored beat, keeping the datagram framing in step.
  assign fifo_mark = data_valid_in && data_last_in && !drop_now && fifo_full;
  assign ovf_event = data_valid_in && (first ? (meta_full || fifo_full)
                                             : (!drop_pkt && fifo_full));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_pkt       <= 1'b0;
      drop_pkt     <= 1'b0;
      overflow_err <= 1'b0;
      meta_wr      <= 1'b0;
      meta_rd      <= 1'b0;
      meta_cnt     <= '0;
      meta_q[0]    <= '0;
      meta_q[1]    <= '0;
    end else begin
      if (data_valid_in) in_pkt <= !data_last_in;
      if (first) drop_pkt <= drop_now;
      if (ovf_event) overflow_err <= 1'b1;
      if (meta_push) begin
        meta_q[meta_wr] <= '{addr: ip_addr_in, len: length_in};
        meta_wr         <= !meta_wr;
      end
      if (meta_pop) meta_rd <= !meta_rd;
      case ({meta_push, meta_pop})
        2'b10:   meta_cnt <= meta_cnt + 2'd1;
        2'b01:   meta_cnt <= meta_cnt - 2'd1;
        default: meta_cnt <= meta_cnt;
      endcase
    end
  end

  ip_stream_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(BEAT_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (fifo_wr),
    .wr_data  ({data_last_in, data_keep_in, data_in}),
    .mark_last(fifo_mark),
    .rd_en    (fifo_rd),
    .rd_data  (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (meta_cnt != 2'd0) state_next = HDR;
      HDR:  if (hdr_idx == 3'(IP_HDR_WORDS - 1)) state_next = DATA;
      DATA: if (!fifo_empty && fifo_rdata[BEAT_W-1]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // header sequencing and per-datagram metadata
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_idx     <= '0;
      ident       <= '0;
      length_out  <= '0;
      ip_addr_out <= '0;
    end else begin
      if (meta_pop) begin
        length_out  <= meta_q[meta_rd].len + 16'(IP_HDR_BYTES);
        ip_addr_out <= meta_q[meta_rd].addr;
        hdr_idx     <= '0;
      end else if (state == HDR) begin
        hdr_idx <= hdr_idx + 3'd1;
      end
      if (state == HDR && hdr_idx == 3'd1) ident <= ident + 16'd1;
    end
  end

`ifdef IP_CHECKSUM_EN
  logic [19:0] sum_r;
  logic [15:0] csum_r;

  // Raw sum in HDR word 0, folded and inverted in word 1, used in word 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_r  <= '0;
      csum_r <= '0;
    end else if (state == HDR && hdr_idx == 3'd0) begin
      sum_r <= 20'({IP_VER_IHL, 8'h00}) + 20'(length_out) + 20'(ident)
             + 20'(IP_FLAGS_DF) + 20'({TTL, IP_PROTO_UDP})
             + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0])
             + 20'(ip_addr_out[31:16]) + 20'(ip_addr_out[15:0]);
    end else if (state == HDR && hdr_idx == 3'd1) begin
      csum_r <= ~fold_sum(sum_r);
    end
  end

  assign csum = csum_r;
`else
  assign csum = '0;
`endif

  always_comb begin
    hdr_word = '0;
    case (hdr_idx)
      3'd0:    hdr_word = {IP_VER_IHL, 8'h00, length_out};
      3'd1:    hdr_word = {ident, IP_FLAGS_DF};
      3'd2:    hdr_word = {TTL, IP_PROTO_UDP, csum};
      3'd3:    hdr_word = SRC_IP;
      3'd4:    hdr_word = ip_addr_out;
      default: hdr_word = '0;
    endcase
  end

  // output logic
  always_comb begin
    data_out       = '0;
    data_valid_out = 1'b0;
    data_keep_out  = '0;
    data_last_out  = 1'b0;
    fifo_rd        = 1'b0;
    case (state)
      HDR: begin
        data_out       = hdr_word;
        data_valid_out = 1'b1;
        data_keep_out  = 4'hF;
      end
      DATA: begin
        fifo_rd = !fifo_empty;
        if (!fifo_empty) begin
          data_out       = fifo_rdata[31:0];
          data_keep_out  = fifo_rdata[35:32];
          data_last_out  = fifo_rdata[36];
          data_valid_out = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
